// File: rtl/boreal_ledger.sv
// rtl/boreal_ledger.sv - append-only event ledger slave with chain digest and one-way seal
module boreal_ledger #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] SEAL_KEY = 32'h5EA1_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ledger_sel,
    input  logic        ledger_wr,
    input  logic [31:0] ledger_addr,
    input  logic [31:0] ledger_wdata,
    output logic [31:0] ledger_rdata,
    output logic        ledger_ack
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [5:0] OFF_STATUS = 6'h00;
    localparam logic [5:0] OFF_APPEND = 6'h01;
    localparam logic [5:0] OFF_COUNT  = 6'h02;
    localparam logic [5:0] OFF_RIDX   = 6'h03;
    localparam logic [5:0] OFF_RDATA  = 6'h04;
    localparam logic [5:0] OFF_SEAL   = 6'h05;
    localparam logic [5:0] OFF_CHAIN  = 6'h06;

    typedef enum logic [1:0] {IDLE, RESP, GAP} state_t;

    state_t              state, next_state;
    logic                accept;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   ridx;
    logic                sealed;
    logic                ovf;
    logic [31:0]         chain;
    logic [31:0]         rd_q;
    logic [31:0]         rd_val;
    logic [31:0]         status;
    logic [31:0]         mem [DEPTH];
    logic                full;
    logic                empty;
    logic                do_append;
    logic [5:0]          offset;
    logic                unused_addr_bits;

    assign offset           = ledger_addr[7:2];
    assign unused_addr_bits = ^{ledger_addr[31:8], ledger_addr[1:0]};
    assign full             = (count == DEPTH_C);
    assign empty            = (count == '0);
    assign do_append        = accept && ledger_wr && (offset == OFF_APPEND) && !sealed && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Side effects happen only on the IDLE->RESP edge, so a late-falling sel cannot repeat them.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (ledger_sel) begin
                accept     = 1'b1;
                next_state = RESP;
            end
            RESP:    next_state = GAP;
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        status                 = '0;
        status[0]              = sealed;
        status[1]              = full;
        status[2]              = empty;
        status[3]              = ovf;
        status[ADDR_W+16:16]   = count;
        rd_val                 = '0;
        case (offset)
            OFF_STATUS: rd_val = status;
            OFF_COUNT:  rd_val = 32'(count);
            OFF_RIDX:   rd_val = 32'(ridx);
            OFF_RDATA:  if ({1'b0, ridx} < count) rd_val = mem[ridx];
            OFF_CHAIN:  rd_val = chain;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            ridx   <= '0;
            sealed <= 1'b0;
            ovf    <= 1'b0;
            chain  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            rd_q <= ledger_wr ? 32'h0 : rd_val;
            if (ledger_wr) begin
                case (offset)
                    OFF_APPEND: begin
                        if (do_append) begin
                            count <= count + 1'b1;
                            chain <= {chain[30:0], chain[31]} ^ ledger_wdata;
                        end else if (!sealed) begin
                            ovf <= 1'b1;
                        end
                    end
                    OFF_RIDX: ridx <= ledger_wdata[ADDR_W-1:0];
                    OFF_SEAL: if (ledger_wdata == SEAL_KEY) sealed <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Entry storage is never cleared; reads are gated by count instead.
    always_ff @(posedge clk) begin
        if (do_append && rst_n) mem[count[ADDR_W-1:0]] <= ledger_wdata;
    end

    assign ledger_ack   = (state == RESP);
    assign ledger_rdata = ledger_ack ? rd_q : 32'h0;
endmodule

// File: tb/tb_boreal_ledger.sv
// tb/tb_boreal_ledger.sv - directed self-checking bench for boreal_ledger
module tb_boreal_ledger;
    localparam logic [31:0] BASE = 32'h1005_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] chain_m;
    logic [31:0] rv;
    logic [3:0]  ack_seq;
    int          lat;

    always #5 clk = ~clk;

    boreal_ledger dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ledger_sel   (sel),
        .ledger_wr    (wr),
        .ledger_addr  (addr),
        .ledger_wdata (wdata),
        .ledger_rdata (rdata),
        .ledger_ack   (ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int cyc);
        @(posedge clk); #1;
        sel = 1'b1; wr = w; addr = a; wdata = d;
        r = '0; cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ack && cyc < 8);
        if (!ack) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout: observed no ack expected ack at addr %h", a);
        end else begin
            r = rdata;
        end
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        int c;
        xact(1'b1, BASE | 32'(off), d, dummy, c);
    endtask

    task automatic rd_reg(input logic [7:0] off, output logic [31:0] r);
        int c;
        xact(1'b0, BASE | 32'(off), 32'h0, r, c);
    endtask

    function automatic logic [31:0] chain_step(input logic [31:0] c, input logic [31:0] d);
        return {c[30:0], c[31]} ^ d;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'b0, ack}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        xact(1'b0, BASE, 32'h0, rv, lat);
        check("status_after_reset", rv, 32'h0000_0004);
        check("read_latency", 32'(lat), 32'd1);
        rd_reg(8'h18, rv);
        check("chain_after_reset", rv, 32'h0);

        chain_m = '0;
        wr_reg(8'h04, 32'h1111_1111); chain_m = chain_step(chain_m, 32'h1111_1111);
        wr_reg(8'h04, 32'h2222_2222); chain_m = chain_step(chain_m, 32'h2222_2222);
        rd_reg(8'h08, rv); check("count_two", rv, 32'd2);
        rd_reg(8'h18, rv); check("chain_two", rv, 32'h0000_0000);
        wr_reg(8'h0C, 32'h1); rd_reg(8'h10, rv); check("rdata_idx1", rv, 32'h2222_2222);
        wr_reg(8'h0C, 32'h5); rd_reg(8'h10, rv); check("rdata_idx5_beyond", rv, 32'h0);
        wr_reg(8'h0C, 32'hFFFF_FF40); rd_reg(8'h0C, rv); check("ridx_masked", rv, 32'h0);
        rd_reg(8'h10, rv); check("rdata_idx0", rv, 32'h1111_1111);
        rd_reg(8'h04, rv); check("append_reads_zero", rv, 32'h0);

        for (int i = 2; i < 64; i++) begin
            wr_reg(8'h04, 32'hA000_0000 | 32'(i));
            chain_m = chain_step(chain_m, 32'hA000_0000 | 32'(i));
        end
        rd_reg(8'h00, rv); check("status_full", rv, 32'h0040_0002);
        wr_reg(8'h04, 32'hDEAD_BEEF);
        rd_reg(8'h00, rv); check("status_full_ovf", rv, 32'h0040_000A);
        xact(1'b0, BASE | 32'h0000_000B, 32'h0, rv, lat); check("count_sat_alias", rv, 32'd64);
        wr_reg(8'h0C, 32'd63); rd_reg(8'h10, rv); check("entry63_kept", rv, 32'hA000_003F);
        rd_reg(8'h18, rv); check("chain_full", rv, chain_m);
        wr_reg(8'h1C, 32'hFFFF_FFFF); rd_reg(8'h1C, rv); check("unmapped_zero", rv, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b1; wr = 1'b1; addr = BASE | 32'h4; wdata = 32'h7777_7777;
        @(posedge clk); #1;
        check("mid_reset_ack_before", {31'b0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_ack_drop", {31'b0, ack}, 32'd0);
        check("mid_reset_rdata", rdata, 32'h0);
        sel = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_reg(8'h00, rv); check("status_post_reset", rv, 32'h0000_0004);
        rd_reg(8'h18, rv); check("chain_post_reset", rv, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b1; wr = 1'b1; addr = BASE | 32'h4; wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ack_seq[i] = ack;
        end
        sel = 1'b0; wr = 1'b0;
        check("hold_ack_pattern", 32'(ack_seq), 32'h9);
        chain_m = chain_step(32'h0, 32'h0BAD_F00D);
        chain_m = chain_step(chain_m, 32'h0BAD_F00D);
        rd_reg(8'h08, rv); check("hold_count", rv, 32'd2);
        rd_reg(8'h18, rv); check("hold_chain", rv, chain_m);

        wr_reg(8'h14, 32'h1234_5678);
        rd_reg(8'h00, rv); check("seal_wrong_key", rv, 32'h0002_0000);
        wr_reg(8'h14, 32'h5EA1_0001);
        rd_reg(8'h00, rv); check("seal_right_key", rv, 32'h0002_0001);
        rd_reg(8'h14, rv); check("seal_reads_zero", rv, 32'h0);
        wr_reg(8'h04, 32'hCAFE_0001);
        rd_reg(8'h00, rv); check("sealed_append_status", rv, 32'h0002_0001);
        rd_reg(8'h18, rv); check("sealed_append_chain", rv, chain_m);
        wr_reg(8'h0C, 32'd2); rd_reg(8'h10, rv); check("sealed_no_entry", rv, 32'h0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
